// File: rtl/mul_div_unit_pkg.sv
// Shared MDU definitions: operation encodings, latency constants and FSM states.
// The CPU decoder imports this package for the MDUOp encodings.
package mul_div_unit_pkg;

    typedef enum logic [3:0] {
        OpNop   = 4'h0,
        OpMult  = 4'h1,
        OpMultU = 4'h2,
        OpDiv   = 4'h3,
        OpDivU  = 4'h4,
        OpMthi  = 4'h5,
        OpMtlo  = 4'h6
    } mdu_op_e;

    localparam int unsigned MULT_CYCLES = 5;
    localparam int unsigned DIV_CYCLES  = 10;
    localparam int unsigned CntW        = 4;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv
    } mdu_state_e;

endpackage

// File: rtl/mul_div_unit.sv
// HI/LO multiply-divide unit: the result is computed and registered at accept,
// then a down-counter holds Busy for the fixed latency before committing it.
module mul_div_unit
    import mul_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUOp,
    input  logic        Start,
    input  logic        Cancel,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    mdu_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic [31:0]     pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic            pend_wr_q, pend_wr_d;

    logic        accept;
    logic        signed_mul, signed_div;
    logic [63:0] mul_a, mul_b, product;
    logic        a_neg, b_neg;
    logic [31:0] abs_a, abs_b, div_b, quo_mag, rem_mag, quo, rem;

    assign accept = Start && !Cancel && (state_q == StIdle);

    // One 64-bit multiplier serves both flavours via operand sign extension.
    assign signed_mul = (MDUOp == OpMult);
    assign mul_a      = {{32{signed_mul & A[31]}}, A};
    assign mul_b      = {{32{signed_mul & B[31]}}, B};
    assign product    = mul_a * mul_b;

    // Signed divide runs on magnitudes; the quotient truncates toward zero and the
    // remainder takes the dividend's sign. 0x80000000 / -1 falls out as 0x80000000.
    assign signed_div = (MDUOp == OpDiv);
    assign a_neg      = signed_div & A[31];
    assign b_neg      = signed_div & B[31];
    assign abs_a      = a_neg ? (32'd0 - A) : A;
    assign abs_b      = b_neg ? (32'd0 - B) : B;
    assign div_b      = (abs_b == 32'd0) ? 32'd1 : abs_b;
    assign quo_mag    = abs_a / div_b;
    assign rem_mag    = abs_a % div_b;
    assign quo        = (a_neg ^ b_neg) ? (32'd0 - quo_mag) : quo_mag;
    assign rem        = a_neg ? (32'd0 - rem_mag) : rem_mag;

    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    unique case (MDUOp)
                        OpMult, OpMultU: begin
                            state_d   = StMul;
                            cnt_d     = CntW'(MULT_CYCLES);
                            pend_hi_d = product[63:32];
                            pend_lo_d = product[31:0];
                            pend_wr_d = 1'b1;
                        end
                        OpDiv, OpDivU: begin
                            state_d   = StDiv;
                            cnt_d     = CntW'(DIV_CYCLES);
                            pend_hi_d = rem;
                            pend_lo_d = quo;
                            pend_wr_d = (B != 32'd0);
                        end
                        OpMthi:  hi_d = A;
                        OpMtlo:  lo_d = A;
                        default: ;
                    endcase
                end
            end
            StMul, StDiv: begin
                if (cnt_q == CntW'(1)) begin
                    state_d = StIdle;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign Busy = (state_q != StIdle);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus queues expected HI/LO and busy length,
// a negedge monitor pops on each Busy fall or explicit idle probe.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic [3:0]  MDUOp;
    logic        Start, Cancel;
    logic        Busy;
    logic [31:0] HI, LO;

    mul_div_unit dut (
        .clk    (clk),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .MDUOp  (MDUOp),
        .Start  (Start),
        .Cancel (Cancel),
        .Busy   (Busy),
        .HI     (HI),
        .LO     (LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          probe;
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   probe_req = 1'b0;
    int   run = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: a completed busy run or a probe request consumes one scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (Busy === 1'b1) begin
            run++;
        end else if (run > 0) begin
            if (sb.size() == 0 || sb[0].probe) begin
                checks++;
                errors++;
                $display("FAIL unexpected_commit: busy run of %0d cycles, no operation expected", run);
            end else begin
                e = sb.pop_front();
                chk("busy_len", 32'(run), 32'(e.len));
                chk("commit_hi", HI, e.hi);
                chk("commit_lo", LO, e.lo);
            end
            run = 0;
        end
        if (probe_req) begin
            probe_req = 1'b0;
            if (sb.size() == 0 || !sb[0].probe) begin
                checks++;
                errors++;
                $display("FAIL probe_order: probe requested but scoreboard head is not a probe");
            end else begin
                e = sb.pop_front();
                chk("probe_busy", {31'd0, Busy}, 32'd0);
                chk("probe_hi", HI, e.hi);
                chk("probe_lo", LO, e.lo);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic cancel);
        MDUOp  = op;
        A      = a;
        B      = b;
        Cancel = cancel;
        Start  = 1'b1;
        tick();
        Start  = 1'b0;
        Cancel = 1'b0;
        MDUOp  = 4'h0;
    endtask

    task automatic expect_op(input logic [31:0] hi, input logic [31:0] lo, input int len);
        sb.push_back('{probe: 1'b0, hi: hi, lo: lo, len: len});
    endtask

    task automatic probe(input logic [31:0] hi, input logic [31:0] lo);
        sb.push_back('{probe: 1'b1, hi: hi, lo: lo, len: 0});
        probe_req = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (Busy === 1'b1 && n < 30) begin
            tick();
            n++;
        end
        if (n >= 30) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: Busy still 1 after %0d cycles, expected 0", n);
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo, input int len);
        expect_op(hi, lo, len);
        issue(op, a, b, 1'b0);
        wait_idle();
    endtask

    initial begin
        reset  = 1'b1;
        A      = '0;
        B      = '0;
        MDUOp  = 4'h0;
        Start  = 1'b0;
        Cancel = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        probe(32'h0, 32'h0);

        run_op(4'h1, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
        run_op(4'h2, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 32'hFFFF_FFFE, 5);
        run_op(4'h3, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        run_op(4'h3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 10);
        run_op(4'h3, 32'h7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 10);
        run_op(4'h4, 32'd100, 32'd7, 32'd2, 32'd14, 10);

        issue(4'h5, 32'h11, 32'h0, 1'b0);
        probe(32'h11, 32'd14);
        issue(4'h6, 32'h22, 32'h0, 1'b0);
        probe(32'h11, 32'h22);
        run_op(4'h4, 32'h1234, 32'h0, 32'h11, 32'h22, 10);
        run_op(4'h3, 32'h1234, 32'h0, 32'h11, 32'h22, 10);

        // Cancel blocks accept; a Start during busy is ignored; MTLO in first idle cycle.
        issue(4'h1, 32'd3, 32'd4, 1'b1);
        probe(32'h11, 32'h22);
        expect_op(32'h0, 32'd12, 5);
        issue(4'h1, 32'd3, 32'd4, 1'b0);
        repeat (2) tick();
        issue(4'h3, 32'd100, 32'd7, 1'b0);
        wait_idle();
        issue(4'h6, 32'd5, 32'h0, 1'b0);
        probe(32'h0, 32'd5);

        issue(4'hF, 32'h99, 32'h1, 1'b0);
        probe(32'h0, 32'd5);
        issue(4'h0, 32'h99, 32'h1, 1'b0);
        probe(32'h0, 32'd5);

        // Reset in busy cycle 7 of a divide discards the pending result.
        HI_LO_SETUP: begin
            issue(4'h5, 32'hAA, 32'h0, 1'b0);
            probe(32'hAA, 32'd5);
        end
        expect_op(32'h0, 32'h0, 7);
        issue(4'h3, 32'd100, 32'd7, 1'b0);
        repeat (6) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (12) tick();
        probe(32'h0, 32'h0);

        repeat (3) tick();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and reset.
REQ-002 Port clk, input, 1: rising-edge clock for all state.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port A, input, 32: first operand (rs); dividend for divides; source for MTHI and MTLO.
REQ-005 Port B, input, 32: second operand (rt); divisor for divides.
REQ-006 Port MDUOp, input, 4: operation code, one of NOP=0000, MULT=0001, MULTU=0010, DIV=0011, DIVU=0100, MTHI=0101, MTLO=0110.
REQ-007 Port Start, input, 1: qualifies MDUOp for one cycle.
REQ-008 Port Cancel, input, 1: exception/interrupt flush; when high, Start is ignored in that cycle.
REQ-009 Port Busy, output, 1: high while a multiply or divide is in flight.
REQ-010 Port HI, output, 32: architectural HI register, driven directly from the register.
REQ-011 Port LO, output, 32: architectural LO register, driven directly from the register.

Function
REQ-012 Accept: the unit SHALL accept an operation at a rising edge when Start=1, Cancel=0, Busy=0 and MDUOp is not NOP or undefined.
REQ-013 MULT/MULTU: compute the signed or unsigned 64-bit product {HI,LO} = A*B and latch it into pending registers at accept.
REQ-014 DIV: signed divide; LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign.
REQ-015 DIV with A=0x80000000 and B=0xFFFFFFFF: LO=0x80000000, HI=0, with no exception.
REQ-016 DIVU: unsigned divide; LO = quotient, HI = remainder.
REQ-017 Divide by zero (B=0, DIV or DIVU): the unit SHALL still run the full busy period, then leave HI and LO unchanged.
REQ-018 Latency: Busy SHALL be high for exactly 5 cycles (multiply) or 10 cycles (divide), starting in the cycle after accept.
REQ-019 Commit: HI and LO SHALL update at the edge that ends the last Busy cycle, so new values are visible in the first cycle with Busy=0.
REQ-020 MTHI/MTLO: when accepted, write A into HI or LO at that edge; Busy stays 0; the other register is unchanged.
REQ-021 Start while Busy=1: ignored, with no state change; upstream stall logic prevents it.
REQ-022 Cancel=1: blocks acceptance only; an operation already in flight runs to completion and commits.
REQ-023 Undefined MDUOp codes, or NOP with Start=1: no effect.
REQ-024 State machine:
  - IDLE -> MUL on an accepted MULT/MULTU, loading the counter with 5.
  - IDLE -> DIV on an accepted DIV/DIVU, loading the counter with 10.
  - MUL/DIV -> IDLE when the counter reaches 1, committing at that edge.
  - The counter decrements every cycle; Busy = (state != IDLE).
REQ-025 Back-to-back: a new operation SHALL be acceptable in the first cycle after Busy falls; operand reads in that cycle see committed HI/LO.

Reset
REQ-026 On reset: HI=0, LO=0, state=IDLE, counter=0, pending registers=0, Busy=0.
REQ-027 Reset SHALL have priority over every other input, including mid-operation: an in-flight result is discarded and never committed.

Structure
REQ-028 A shared package SHALL hold the MDUOp encodings and the latency constants MULT_CYCLES=5 and DIV_CYCLES=10; the CPU decoder uses the same package.
REQ-029 No sub-module is required: arithmetic is inline, registered at accept, and the counter-based FSM only delays the commit.

Verification
REQ-030 MULT A=0xFFFFFFFF, B=0x00000002 -> Busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-031 MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
REQ-032 DIV A=0xFFFFFFF9 (-7), B=2 -> Busy high for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-033 With HI=0x11, LO=0x22, DIVU B=0 -> Busy for 10 cycles; HI=0x11 and LO=0x22 unchanged.
REQ-034 Back-to-back:
  - Start MULT with Cancel=1 -> no Busy.
  - Start DIV at busy cycle 3 -> ignored.
  - MTLO A=5 in the first idle cycle -> LO=5 next cycle, HI keeps the product.
REQ-035 Reset asserted during busy cycle 7 of a DIV -> Busy=0 and HI=LO=0 next cycle; no late commit.
